// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the vending-machine key input stage: key indices, clock rate,
// the default debounce length and the per-key status record.
package key_conditioner_pkg;

    localparam int KEY_COIN  = 0;
    localparam int KEY_BUY   = 1;
    localparam int KEY_SPARE = 2;

    localparam int CLK_HZ                  = 50_000_000;
    localparam int DEBOUNCE_MS             = 1;
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int N_KEYS_DEFAULT          = 3;

    typedef struct packed {
        logic pressed;
        logic press_valid;
        logic overrun;
    } key_status_t;

endpackage

// File: rtl/key_debounce_channel.sv
// One button: 2-flop sync, debounce counter, stable level and press event with overrun flag.
// Press visible DEBOUNCE_CYCLES+1 edges after first low sample; event held until press_ack.
module key_debounce_channel
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        key_n,
    input  logic        press_ack,
    output key_status_t status
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_out;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             pend;
    logic             ovr;
    logic             differs;
    logic             accept;
    logic             press_evt;

    assign differs   = (sync_out != stable);
    assign accept    = differs && (cnt == CNT_MAX);
    // Only the released-to-held transition is an event; releases just move the level.
    assign press_evt = accept && !sync_out;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_meta <= 1'b1;
            sync_out  <= 1'b1;
            stable    <= 1'b1;
            cnt       <= '0;
            pend      <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            sync_meta <= key_n;
            sync_out  <= sync_meta;

            if (!differs) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync_out;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A press landing on an unconsumed event is dropped and remembered.
            if (press_evt) begin
                pend <= 1'b1;
                if (pend && !press_ack) begin
                    ovr <= 1'b1;
                end
            end else if (press_ack) begin
                pend <= 1'b0;
            end
        end
    end

    assign status.pressed     = ~stable;
    assign status.press_valid = pend;
    assign status.overrun     = ovr;

endmodule

// File: rtl/key_conditioner.sv
// Conditions N_KEYS raw active-low buttons into debounced levels and one-shot press events.
// Latency DEBOUNCE_CYCLES+1 edges per accepted level; each event held until its press_ack bit.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int N_KEYS          = N_KEYS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] press_valid,
    input  logic [N_KEYS-1:0] press_ack,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] overrun
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_status_t st;

        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clock     (clock),
            .reset_n   (reset_n),
            .key_n     (key_n[i]),
            .press_ack (press_ack[i]),
            .status    (st)
        );

        assign pressed[i]     = st.pressed;
        assign press_valid[i] = st.press_valid;
        assign overrun[i]     = st.overrun;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with a 4-cycle debounce: stimulus queues the
// expected output transitions, a negedge monitor matches every observed transition.
module tb_key_conditioner;
    import key_conditioner_pkg::*;

    localparam int NK     = 3;
    localparam int EV_PRS = 0;
    localparam int EV_PV  = 1;
    localparam int EV_OV  = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] press_ack;
    logic [NK-1:0] press_valid;
    logic [NK-1:0] pressed;
    logic [NK-1:0] overrun;

    key_conditioner #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .key_n       (key_n),
        .press_valid (press_valid),
        .press_ack   (press_ack),
        .pressed     (pressed),
        .overrun     (overrun)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int   kind;
        int   key;
        logic val;
        int   at;
    } ev_t;

    ev_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    function automatic string kname(int kind);
        case (kind)
            EV_PRS:  return "pressed";
            EV_PV:   return "press_valid";
            default: return "overrun";
        endcase
    endfunction

    task automatic expect_ev(int kind, int key, logic val, int at);
        ev_t e;
        e.kind = kind;
        e.key  = key;
        e.val  = val;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(int kind, int key, logic val);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: %s[%0d] -> %b at cycle %0d, none expected",
                     kname(kind), key, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.key != key || e.val !== val || e.at != cyc) begin
                miscompares++;
                $display("FAIL event: got %s[%0d] -> %b at cycle %0d, expected %s[%0d] -> %b at cycle %0d",
                         kname(kind), key, val, cyc, kname(e.kind), e.key, e.val, e.at);
            end
        end
    endtask

    task automatic check_val(string name, logic [NK-1:0] act, logic [NK-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clock);
    endtask

    logic [NK-1:0] prev_p = '0;
    logic [NK-1:0] prev_v = '0;
    logic [NK-1:0] prev_o = '0;

    always @(negedge clock) begin
        for (int k = 0; k < NK; k++) begin
            if (pressed[k] !== prev_p[k])     check_ev(EV_PRS, k, pressed[k]);
            if (press_valid[k] !== prev_v[k]) check_ev(EV_PV, k, press_valid[k]);
            if (overrun[k] !== prev_o[k])     check_ev(EV_OV, k, overrun[k]);
        end
        prev_p <= pressed;
        prev_v <= press_valid;
        prev_o <= overrun;
    end

    initial begin
        int c;
        reset_n   = 1'b0;
        key_n     = '0;
        press_ack = '0;

        // Reset with all keys held low: nothing may leak out.
        tick(2);
        check_val("reset_press_valid", press_valid, 3'b000);
        check_val("reset_pressed", pressed, 3'b000);
        check_val("reset_overrun", overrun, 3'b000);
        reset_n = 1'b1;
        key_n   = '1;
        tick(10);

        // Clean press on the coin key, held until acknowledged.
        c = cyc;
        key_n[KEY_COIN] = 1'b0;
        expect_ev(EV_PRS, KEY_COIN, 1'b1, c + 6);
        expect_ev(EV_PV,  KEY_COIN, 1'b1, c + 6);
        tick(9);
        check_val("press_held_until_ack", press_valid, 3'b001);
        c = cyc;
        press_ack = 3'b001;
        expect_ev(EV_PV, KEY_COIN, 1'b0, c + 1);
        tick(1);
        press_ack = '0;
        check_val("press_cleared_by_ack", press_valid, 3'b000);
        c = cyc;
        key_n[KEY_COIN] = 1'b1;
        expect_ev(EV_PRS, KEY_COIN, 1'b0, c + 6);
        tick(10);

        // Bounce on the buy key never lasts long enough to be accepted.
        repeat (2) begin
            key_n[KEY_BUY] = 1'b0;
            tick(2);
            key_n[KEY_BUY] = 1'b1;
            tick(2);
        end
        tick(10);
        check_val("bounce_pressed", pressed, 3'b000);
        check_val("bounce_press_valid", press_valid, 3'b000);

        // Two presses without an ack: second one is dropped and flagged.
        c = cyc;
        key_n[KEY_COIN] = 1'b0;
        expect_ev(EV_PRS, KEY_COIN, 1'b1, c + 6);
        expect_ev(EV_PV,  KEY_COIN, 1'b1, c + 6);
        tick(8);
        c = cyc;
        key_n[KEY_COIN] = 1'b1;
        expect_ev(EV_PRS, KEY_COIN, 1'b0, c + 6);
        tick(8);
        c = cyc;
        key_n[KEY_COIN] = 1'b0;
        expect_ev(EV_PRS, KEY_COIN, 1'b1, c + 6);
        expect_ev(EV_OV,  KEY_COIN, 1'b1, c + 6);
        tick(8);
        check_val("overrun_press_valid", press_valid, 3'b001);
        check_val("overrun_set", overrun, 3'b001);
        c = cyc;
        press_ack = 3'b001;
        expect_ev(EV_PV, KEY_COIN, 1'b0, c + 1);
        tick(1);
        press_ack = '0;
        check_val("overrun_ack_clears_valid", press_valid, 3'b000);
        check_val("overrun_sticky", overrun, 3'b001);
        c = cyc;
        key_n[KEY_COIN] = 1'b1;
        expect_ev(EV_PRS, KEY_COIN, 1'b0, c + 6);
        tick(8);

        // All three keys pressed together, acknowledged in two groups.
        c = cyc;
        key_n = 3'b000;
        for (int k = 0; k < NK; k++) begin
            expect_ev(EV_PRS, k, 1'b1, c + 6);
            expect_ev(EV_PV,  k, 1'b1, c + 6);
        end
        tick(7);
        check_val("simul_press_valid", press_valid, 3'b111);
        c = cyc;
        press_ack = 3'b001;
        expect_ev(EV_PV, KEY_COIN, 1'b0, c + 1);
        tick(1);
        press_ack = '0;
        check_val("simul_ack_001", press_valid, 3'b110);
        c = cyc;
        press_ack = 3'b110;
        expect_ev(EV_PV, KEY_BUY,   1'b0, c + 1);
        expect_ev(EV_PV, KEY_SPARE, 1'b0, c + 1);
        tick(1);
        press_ack = '0;
        check_val("simul_ack_110", press_valid, 3'b000);
        c = cyc;
        key_n = 3'b111;
        for (int k = 0; k < NK; k++) expect_ev(EV_PRS, k, 1'b0, c + 6);
        tick(8);

        // Reset lands mid-debounce on the spare key; acceptance restarts from scratch.
        c = cyc;
        key_n[KEY_SPARE] = 1'b0;
        tick(2);
        expect_ev(EV_OV, KEY_COIN, 1'b0, c + 3);
        reset_n = 1'b0;
        tick(2);
        check_val("midreset_press_valid", press_valid, 3'b000);
        check_val("midreset_pressed", pressed, 3'b000);
        check_val("midreset_overrun", overrun, 3'b000);
        reset_n = 1'b1;
        expect_ev(EV_PRS, KEY_SPARE, 1'b1, c + 10);
        expect_ev(EV_PV,  KEY_SPARE, 1'b1, c + 10);
        tick(5);
        check_val("midreset_not_early", press_valid, 3'b000);
        tick(1);
        check_val("midreset_full_latency", press_valid, 3'b100);
        c = cyc;
        press_ack = 3'b100;
        expect_ev(EV_PV, KEY_SPARE, 1'b0, c + 1);
        tick(1);
        press_ack = '0;
        c = cyc;
        key_n[KEY_SPARE] = 1'b1;
        expect_ev(EV_PRS, KEY_SPARE, 1'b0, c + 6);
        tick(10);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_events: got %0d outstanding, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
